// File: rtl/ring_counter_gen.sv
// Shift-register sequence counter: one-hot ring or Johnson, bidirectional,
// with load-by-step-index, step index output, wrap pulse and sticky load fault.
module ring_counter_gen #(
  parameter  int N  = 4,
  localparam int PW = $clog2(2*N)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          En,
  input  logic          Mode,
  input  logic          Dir,
  input  logic          Load,
  input  logic [PW-1:0] LoadPos,
  output logic [N-1:0]  q,
  output logic [PW-1:0] pos,
  output logic          wrap,
  output logic          fault
);

  logic          mode_q;
  logic [N-1:0]  q_n;
  logic [PW-1:0] pos_n;
  logic          wrap_n, fault_n, mode_n;
  logic [PW:0]   mod_m, last;
  logic          at_last, at_zero;

  // Step k pattern: ring = one-hot bit k; Johnson = low k bits set up to N,
  // then the top 2N-k bits set (equivalently bits k-N..N-1).
  function automatic logic [N-1:0] pattern(input logic m, input logic [PW-1:0] k);
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) begin
      if (!m)                 p[i] = (i == int'(k));
      else if (int'(k) <= N)  p[i] = (i < int'(k));
      else                    p[i] = (i >= int'(k) - N);
    end
    return p;
  endfunction

  assign mod_m   = mode_q ? (PW+1)'(2*N) : (PW+1)'(N);
  assign last    = mod_m - (PW+1)'(1);
  assign at_last = ({1'b0, pos} == last);
  assign at_zero = (pos == '0);

  always_comb begin
    q_n     = q;
    pos_n   = pos;
    wrap_n  = 1'b0;
    fault_n = fault;
    mode_n  = mode_q;
    if (Mode != mode_q) begin
      q_n    = pattern(Mode, PW'(0));
      pos_n  = '0;
      mode_n = Mode;
    end else if (Load) begin
      if ({1'b0, LoadPos} < mod_m) begin
        q_n   = pattern(mode_q, LoadPos);
        pos_n = LoadPos;
      end else begin
        fault_n = 1'b1;
      end
    end else if (En) begin
      if (!Dir) begin
        q_n    = mode_q ? {q[N-2:0], ~q[N-1]} : {q[N-2:0], q[N-1]};
        pos_n  = at_last ? '0 : pos + PW'(1);
        wrap_n = at_last;
      end else begin
        q_n    = mode_q ? {~q[0], q[N-1:1]} : {q[0], q[N-1:1]};
        pos_n  = at_zero ? last[PW-1:0] : pos - PW'(1);
        wrap_n = at_zero;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      q      <= pattern(Mode, PW'(0));
      pos    <= '0;
      wrap   <= 1'b0;
      fault  <= 1'b0;
      mode_q <= Mode;
    end else begin
      q      <= q_n;
      pos    <= pos_n;
      wrap   <= wrap_n;
      fault  <= fault_n;
      mode_q <= mode_n;
    end
  end

endmodule

// File: tb/tb_ring_counter_gen.sv
// Scoreboard bench for ring_counter_gen: an N=4 instance driven from a vector
// table and an N=5 instance driven by a hand-written Johnson load/fault sequence.
module tb_ring_counter_gen;

  typedef struct {
    logic       rst, en, mode, dir, load;
    logic [3:0] lpos;
    logic [7:0] eq;
    logic [3:0] epos;
    logic       ew, ef;
  } vec_t;

  typedef struct {
    int   d;
    vec_t v;
  } sb_t;

  logic Clock = 0;
  always #5 Clock = ~Clock;

  logic       rst4 = 1, en4 = 0, mode4 = 0, dir4 = 0, load4 = 0;
  logic [2:0] lp4 = '0;
  logic [3:0] q4;
  logic [2:0] pos4;
  logic       wrap4, fault4;

  logic       rst5 = 1, en5 = 0, mode5 = 0, dir5 = 0, load5 = 0;
  logic [3:0] lp5 = '0;
  logic [4:0] q5;
  logic [3:0] pos5;
  logic       wrap5, fault5;

  ring_counter_gen #(.N(4)) dut4 (
    .Clock(Clock), .Reset(rst4), .En(en4), .Mode(mode4), .Dir(dir4),
    .Load(load4), .LoadPos(lp4), .q(q4), .pos(pos4), .wrap(wrap4), .fault(fault4));

  ring_counter_gen #(.N(5)) dut5 (
    .Clock(Clock), .Reset(rst5), .En(en5), .Mode(mode5), .Dir(dir5),
    .Load(load5), .LoadPos(lp5), .q(q5), .pos(pos5), .wrap(wrap5), .fault(fault5));

  sb_t sb[$];
  int  checks = 0;
  int  failures = 0;

  function automatic vec_t mk(input logic rst, en, mode, dir, load, input logic [3:0] lpos,
                              input logic [7:0] eq, input logic [3:0] epos, input logic ew, ef);
    vec_t v;
    v.rst = rst; v.en = en; v.mode = mode; v.dir = dir; v.load = load; v.lpos = lpos;
    v.eq = eq; v.epos = epos; v.ew = ew; v.ef = ef;
    return v;
  endfunction

  // Drive one edge's worth of inputs and queue the outputs expected after it.
  task automatic step(input int d, input vec_t v);
    @(negedge Clock);
    if (d == 4) begin
      rst4 = v.rst; en4 = v.en; mode4 = v.mode; dir4 = v.dir; load4 = v.load; lp4 = v.lpos[2:0];
      rst5 = 0; en5 = 0; load5 = 0;
    end else begin
      rst5 = v.rst; en5 = v.en; mode5 = v.mode; dir5 = v.dir; load5 = v.load; lp5 = v.lpos;
      rst4 = 0; en4 = 0; load4 = 0;
    end
    sb.push_back('{d: d, v: v});
  endtask

  always @(posedge Clock) begin
    #1;
    if (sb.size() > 0) begin
      sb_t e;
      logic [7:0] aq;
      logic [3:0] ap;
      logic aw, af;
      e = sb.pop_front();
      if (e.d == 4) begin aq = {4'b0, q4}; ap = {1'b0, pos4}; aw = wrap4; af = fault4; end
      else          begin aq = {3'b0, q5}; ap = pos5;         aw = wrap5; af = fault5; end
      checks++;
      if (aq !== e.v.eq || ap !== e.v.epos || aw !== e.v.ew || af !== e.v.ef) begin
        failures++;
        $display("FAIL n%0d_step%0d: got q=%b pos=%0d wrap=%b fault=%b, want q=%b pos=%0d wrap=%b fault=%b",
                 e.d, checks, aq, ap, aw, af, e.v.eq, e.v.epos, e.v.ew, e.v.ef);
      end
    end
  end

  vec_t tbl[$];

  initial begin
    //           rst en md dr ld lpos   q            pos w  f
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'b0001, 0, 0, 0));  // reset, ring
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'b0010, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'b0100, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'b1000, 3, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'b0001, 0, 1, 0));  // wrap up
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 8'b1000, 3, 1, 0));  // wrap down
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'b1000, 3, 0, 0));  // hold, wrap drops
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'b0000, 0, 0, 0));  // to Johnson
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 8'b0001, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 8'b0011, 2, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 8'b0111, 3, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 8'b1111, 4, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 8'b1110, 5, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 8'b1100, 6, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 8'b1000, 7, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 8'b0000, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 8'b1000, 7, 1, 0));  // Johnson wrap down
    tbl.push_back(mk(0, 0, 1, 0, 1, 5, 8'b1110, 5, 0, 0));  // load
    tbl.push_back(mk(0, 1, 1, 0, 1, 2, 8'b0011, 2, 0, 0));  // load beats En
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'b0001, 0, 0, 0));  // back to ring
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 8'b0100, 2, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 3, 8'b0000, 0, 0, 0));  // mode change beats Load/En
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 5, 8'b0001, 0, 0, 1));  // out-of-range load
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'b0010, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 2, 8'b0001, 0, 0, 0));  // reset beats Load/En
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'b0001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'b0001, 0, 0, 0));
    foreach (tbl[i]) step(4, tbl[i]);

    // N=5 Johnson: step 7 is the top three bits set.
    step(5, mk(1, 0, 1, 0, 0, 0,  8'b00000, 0, 0, 0));
    step(5, mk(0, 0, 1, 0, 1, 7,  8'b11100, 7, 0, 0));
    step(5, mk(0, 0, 1, 0, 1, 12, 8'b11100, 7, 0, 1));
    begin
      logic [4:0] jq[10] = '{5'b11000, 5'b10000, 5'b00000, 5'b00001, 5'b00011,
                             5'b00111, 5'b01111, 5'b11111, 5'b11110, 5'b11100};
      logic [3:0] jp[10] = '{8, 9, 0, 1, 2, 3, 4, 5, 6, 7};
      for (int i = 0; i < 10; i++)
        step(5, mk(0, 1, 1, 0, 0, 0, {3'b0, jq[i]}, jp[i], (i == 2), 1));
    end
    step(5, mk(1, 0, 1, 0, 0, 0, 8'b00000, 0, 0, 0));

    begin
      int budget;
      budget = 0;
      @(negedge Clock);
      rst4 = 0; en4 = 0; load4 = 0; rst5 = 0; en5 = 0; load5 = 0;
      while (sb.size() > 0 && budget < 20) begin
        @(negedge Clock);
        budget++;
      end
      if (sb.size() > 0) begin
        failures++;
        $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
